// File: rtl/counter_game_pkg.sv
// ---------------------------------------------------------------------------
// counter_game_pkg
//
// Purpose:
//   Shared types and constants for the counter game observer: the event
//   kinds, the encoding of the 'who' result bus, and the record type stored
//   in the observer's event FIFO.
//
// Contents:
//   evt_kind_e       WIN, LOSE, GAME_WIN, GAME_LOSE (2-bit encoding)
//   WHO_WIN/WHO_LOSE legal 'who' values when gameover rises
//   evt_rec_t        packed event record (kind, tally, counter, and the
//                    optional timestamp field)
//   who_is_valid     true when 'who' names exactly one side
//   game_kind_of     maps a legal 'who' value to its GAME_* event kind
//
// Configuration:
//   OBS_TIMESTAMP_EN  when defined, evt_rec_t carries a 16-bit timestamp.
// ---------------------------------------------------------------------------
package counter_game_pkg;

    // The record's tally field is sized for the widest tally the observer
    // is expected to be built with; narrower tallies are zero-extended on
    // the way in and sliced back down on the way out.
    localparam int EVT_TALLY_MAX_W = 16;

    localparam int EVT_TIME_W = 16;

    localparam logic [1:0] WHO_WIN  = 2'b10;
    localparam logic [1:0] WHO_LOSE = 2'b01;

    typedef enum logic [1:0] {
        WIN       = 2'b00,
        LOSE      = 2'b01,
        GAME_WIN  = 2'b10,
        GAME_LOSE = 2'b11
    } evt_kind_e;

    typedef struct packed {
        evt_kind_e                  kind;
        logic [EVT_TALLY_MAX_W-1:0] tally;
        logic [3:0]                 counter;
`ifdef OBS_TIMESTAMP_EN
        logic [EVT_TIME_W-1:0]      stamp;
`endif
    } evt_rec_t;

    // A finished game must name exactly one side; 00 and 11 are treated
    // as protocol violations by the observer.
    function automatic logic who_is_valid(input logic [1:0] whoVal);
        return (whoVal == WHO_WIN) || (whoVal == WHO_LOSE);
    endfunction

    // Only meaningful when who_is_valid() holds.
    function automatic evt_kind_e game_kind_of(input logic [1:0] whoVal);
        return (whoVal == WHO_WIN) ? GAME_WIN : GAME_LOSE;
    endfunction

endpackage

// File: rtl/obs_event_fifo.sv
// ---------------------------------------------------------------------------
// obs_event_fifo
//
// Purpose:
//   Small first-word-fall-through FIFO holding observer event records.
//   The head entry is presented on o_data whenever o_empty is low. There is
//   no write-to-read bypass: a record pushed into an empty FIFO becomes
//   visible on the following cycle.
//
// Parameters:
//   DEPTH  number of entries; must be a power of two, at least 2
//   T      record type stored per entry
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   synchronous active-high reset; empties the FIFO
//   i_push   in   write i_data this cycle
//   i_data   in   record to write
//   i_pop    in   retire the head entry (ignored while empty)
//   o_data   out  head record
//   o_full   out  all DEPTH entries occupied
//   o_empty  out  no entries occupied
// ---------------------------------------------------------------------------
module obs_event_fifo
    import counter_game_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = evt_rec_t
) (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    T               r_mem [DEPTH];
    logic [PTR_W:0] r_wrPtr;
    logic [PTR_W:0] r_rdPtr;
    logic           w_doPush;
    logic           w_doPop;

    // Pointers carry one extra wrap bit so that full and empty can be told
    // apart when the index bits are equal.
    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]) &&
                     (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]);

    // A pop frees a slot in the same cycle, so a full FIFO can accept a
    // push when it is also being popped. A pop on an empty FIFO does
    // nothing, which is also why a push into an empty FIFO cannot be
    // consumed in the same cycle.
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    // Read and write pointers advance independently; reset discards every
    // queued entry by making the pointers equal again.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
        end
    end

    // Storage array. Entries are not reset: a slot is only ever read after
    // it has been written, because the read pointer never passes the write
    // pointer.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= i_data;
        end
    end

    assign o_data = r_mem[r_rdPtr[PTR_W-1:0]];

endmodule

// File: rtl/counter_game_observer.sv
// ---------------------------------------------------------------------------
// counter_game_observer
//
// Purpose:
//   Passive observer on the output side of the up/down counter game. It
//   edge-detects winner/loser/gameover, keeps its own win/lose/game tallies,
//   flags protocol violations, and queues one event record per cycle into a
//   FIFO that a valid/ready reader drains. It never drives the counter.
//
// Parameters:
//   TALLY_W  width of win/lose tallies and evt_tally (at most 16)
//   DEPTH    event FIFO depth; power of two, at least 2
//   GAMES_W  width of games_played
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   synchronous active-high reset
//   counter       in   game counter value
//   winner        in   win flag
//   loser         in   lose flag
//   gameover      in   game-over flag
//   who           in   game result: 10 win side, 01 lose side
//   evt_valid     out  FIFO head is valid
//   evt_ready     in   reader accepts the head
//   evt_kind      out  00 WIN, 01 LOSE, 10 GAME_WIN, 11 GAME_LOSE
//   evt_tally     out  tally captured with the event
//   evt_counter   out  counter value sampled in the event cycle
//   evt_time      out  head timestamp (only with OBS_TIMESTAMP_EN)
//   win_tally     out  running win count
//   lose_tally    out  running lose count
//   games_played  out  completed games
//   overflow      out  sticky: an event was dropped on a full FIFO
//   proto_err     out  sticky: protocol violation detected
//
// Configuration:
//   OBS_TIMESTAMP_EN  adds a free-running 16-bit cycle counter, stores its
//                     value with each event and exposes it on evt_time.
// ---------------------------------------------------------------------------
module counter_game_observer
    import counter_game_pkg::*;
#(
    parameter int TALLY_W = 4,
    parameter int DEPTH   = 4,
    parameter int GAMES_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         counter,
    input  logic               winner,
    input  logic               loser,
    input  logic               gameover,
    input  logic [1:0]         who,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [1:0]         evt_kind,
    output logic [TALLY_W-1:0] evt_tally,
    output logic [3:0]         evt_counter,
`ifdef OBS_TIMESTAMP_EN
    output logic [15:0]        evt_time,
`endif
    output logic [TALLY_W-1:0] win_tally,
    output logic [TALLY_W-1:0] lose_tally,
    output logic [GAMES_W-1:0] games_played,
    output logic               overflow,
    output logic               proto_err
);

    localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);
    localparam logic [GAMES_W-1:0] GAMES_ONE = GAMES_W'(1);

    logic               r_winnerQ;
    logic               r_loserQ;
    logic               r_gameoverQ;
    logic [TALLY_W-1:0] r_winTally;
    logic [TALLY_W-1:0] r_loseTally;
    logic [GAMES_W-1:0] r_games;
    logic               r_overflow;
    logic               r_protoErr;
`ifdef OBS_TIMESTAMP_EN
    logic [15:0]        r_cycle;
`endif

    logic               w_riseWin;
    logic               w_riseLose;
    logic               w_riseGame;
    logic [TALLY_W-1:0] w_nextWin;
    logic [TALLY_W-1:0] w_nextLose;
    logic [GAMES_W-1:0] w_nextGames;
    logic               w_setErr;
    logic               w_push;
    logic               w_pop;
    evt_rec_t           w_pushRec;
    evt_rec_t           w_head;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    logic [EVT_TALLY_MAX_W-1:0] w_unusedTally;

    // Previous-cycle copies of the three game flags. Clearing them on reset
    // means a flag that is already high in the first cycle after reset is
    // seen as a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winnerQ   <= 1'b0;
            r_loserQ    <= 1'b0;
            r_gameoverQ <= 1'b0;
        end else begin
            r_winnerQ   <= winner;
            r_loserQ    <= loser;
            r_gameoverQ <= gameover;
        end
    end

    assign w_riseWin  = winner   & ~r_winnerQ;
    assign w_riseLose = loser    & ~r_loserQ;
    assign w_riseGame = gameover & ~r_gameoverQ;

    // Event decode. At most one record is pushed per cycle and a gameover
    // edge takes precedence over any winner/loser edge in the same cycle,
    // since the tallies are about to be cleared anyway; with an illegal
    // 'who' the whole cycle is reported as a violation and nothing else
    // happens. The GAME_* record carries the win tally as it stood before
    // this cycle, for both game outcomes. Simultaneous winner and loser
    // edges contradict each other, so neither is counted.
    always_comb begin
        w_nextWin   = r_winTally;
        w_nextLose  = r_loseTally;
        w_nextGames = r_games;
        w_setErr    = 1'b0;
        w_push      = 1'b0;
        w_pushRec   = '0;

        if (w_riseGame) begin
            if (who_is_valid(who)) begin
                w_push          = 1'b1;
                w_pushRec.kind  = game_kind_of(who);
                w_pushRec.tally = EVT_TALLY_MAX_W'(r_winTally);
                w_nextWin       = '0;
                w_nextLose      = '0;
                w_nextGames     = r_games + GAMES_ONE;
            end else begin
                w_setErr = 1'b1;
            end
        end else if (w_riseWin && w_riseLose) begin
            w_setErr = 1'b1;
        end else if (w_riseWin) begin
            w_nextWin       = r_winTally + TALLY_ONE;
            w_push          = 1'b1;
            w_pushRec.kind  = WIN;
            w_pushRec.tally = EVT_TALLY_MAX_W'(w_nextWin);
        end else if (w_riseLose) begin
            w_nextLose      = r_loseTally + TALLY_ONE;
            w_push          = 1'b1;
            w_pushRec.kind  = LOSE;
            w_pushRec.tally = EVT_TALLY_MAX_W'(w_nextLose);
        end

        w_pushRec.counter = counter;
`ifdef OBS_TIMESTAMP_EN
        w_pushRec.stamp   = r_cycle;
`endif
    end

    assign w_pop = evt_valid & evt_ready;

    // Tallies, game count and the sticky flags. The tallies follow the
    // decode above even when the FIFO drops the matching record. Overflow
    // is only raised for a push into a full FIFO that is not popped in the
    // same cycle, because a simultaneous pop makes room for it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_winTally  <= '0;
            r_loseTally <= '0;
            r_games     <= '0;
            r_overflow  <= 1'b0;
            r_protoErr  <= 1'b0;
        end else begin
            r_winTally  <= w_nextWin;
            r_loseTally <= w_nextLose;
            r_games     <= w_nextGames;
            if (w_push && w_fifoFull && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_setErr) begin
                r_protoErr <= 1'b1;
            end
        end
    end

`ifdef OBS_TIMESTAMP_EN
    // Free-running cycle counter used to timestamp events; it wraps
    // silently and restarts from zero on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 16'd1;
        end
    end
`endif

    obs_event_fifo #(
        .DEPTH (DEPTH),
        .T     (evt_rec_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_pushRec),
        .i_pop   (evt_ready),
        .o_data  (w_head),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // The head fields are forced to zero while the FIFO is empty so that
    // the reader never sees stale or uninitialised storage, including right
    // after reset.
    assign evt_valid     = ~w_fifoEmpty;
    assign evt_kind      = evt_valid ? w_head.kind : 2'b00;
    assign evt_tally     = evt_valid ? w_head.tally[TALLY_W-1:0] : '0;
    assign evt_counter   = evt_valid ? w_head.counter : 4'h0;
`ifdef OBS_TIMESTAMP_EN
    assign evt_time      = evt_valid ? w_head.stamp : 16'h0000;
`endif

    // The record's tally field is wider than this build's tally; the upper
    // bits are always zero and are deliberately left unconsumed.
    assign w_unusedTally = w_head.tally >> TALLY_W;

    assign win_tally     = r_winTally;
    assign lose_tally    = r_loseTally;
    assign games_played  = r_games;
    assign overflow      = r_overflow;
    assign proto_err     = r_protoErr;

endmodule

// File: tb/tb_counter_game_observer.sv
// ---------------------------------------------------------------------------
// tb_counter_game_observer
//
// Purpose:
//   Self-checking bench for counter_game_observer: a table of hand-computed
//   vectors, a few directed multi-cycle sequences, and a randomized run
//   compared against a queue-based reference model of the observer.
//
// Configuration:
//   OBS_TIMESTAMP_EN  when defined, evt_time is connected and checked.
// ---------------------------------------------------------------------------
module tb_counter_game_observer;

    localparam int TALLY_W = 4;
    localparam int DEPTH   = 4;
    localparam int GAMES_W = 8;
    localparam int TALLY_MOD = 1 << TALLY_W;
    localparam int GAMES_MOD = 1 << GAMES_W;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         counter;
    logic               winner;
    logic               loser;
    logic               gameover;
    logic [1:0]         who;
    logic               evt_valid;
    logic               evt_ready;
    logic [1:0]         evt_kind;
    logic [TALLY_W-1:0] evt_tally;
    logic [3:0]         evt_counter;
`ifdef OBS_TIMESTAMP_EN
    logic [15:0]        evt_time;
`endif
    logic [TALLY_W-1:0] win_tally;
    logic [TALLY_W-1:0] lose_tally;
    logic [GAMES_W-1:0] games_played;
    logic               overflow;
    logic               proto_err;

    counter_game_observer #(
        .TALLY_W (TALLY_W),
        .DEPTH   (DEPTH),
        .GAMES_W (GAMES_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .counter      (counter),
        .winner       (winner),
        .loser        (loser),
        .gameover     (gameover),
        .who          (who),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_kind     (evt_kind),
        .evt_tally    (evt_tally),
        .evt_counter  (evt_counter),
`ifdef OBS_TIMESTAMP_EN
        .evt_time     (evt_time),
`endif
        .win_tally    (win_tally),
        .lose_tally   (lose_tally),
        .games_played (games_played),
        .overflow     (overflow),
        .proto_err    (proto_err)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    // Reference model state: plain integers and a queue of event records.
    typedef struct {
        int kind;
        int tally;
        int cnt;
        int stamp;
    } mrec_t;

    mrec_t mQ[$];
    int    mWin;
    int    mLose;
    int    mGames;
    int    mTime;
    bit    mOvf;
    bit    mPerr;
    bit    pW;
    bit    pL;
    bit    pG;

    int compared   = 0;
    int mismatched = 0;

    // Hand-computed vector table record.
    typedef struct {
        bit         rst;
        logic [3:0] cnt;
        bit         w;
        bit         l;
        bit         g;
        logic [1:0] wh;
        bit         rdy;
        bit         eValid;
        int         eKind;
        int         eTally;
        int         eCnt;
        int         eWin;
        int         eLose;
        int         eGames;
        bit         eOvf;
        bit         ePerr;
    } vec_t;

    vec_t vecs[$];

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock of the observer, described from the rules: edges are new
    // highs, a game edge dominates, an illegal game or contradictory
    // win/lose edge only raises the error flag, and the FIFO is a bounded
    // queue where a pop of the old contents frees space for the new event.
    task automatic modelStep(input bit rst, input logic [3:0] cnt, input bit w,
                             input bit l, input bit g, input logic [1:0] wh,
                             input bit rdy);
        mrec_t r;
        bit    doPush;
        bit    popNow;
        int    preSize;
        if (rst) begin
            mQ.delete();
            mWin = 0; mLose = 0; mGames = 0; mTime = 0;
            mOvf = 0; mPerr = 0; pW = 0; pL = 0; pG = 0;
        end else begin
            doPush  = 0;
            r       = '{kind: 0, tally: 0, cnt: int'(cnt), stamp: mTime};
            preSize = mQ.size();
            popNow  = rdy && (preSize > 0);
            if (g && !pG) begin
                if (wh == 2'b10 || wh == 2'b01) begin
                    r.kind  = (wh == 2'b10) ? 2 : 3;
                    r.tally = mWin;
                    doPush  = 1;
                    mWin    = 0;
                    mLose   = 0;
                    mGames  = (mGames + 1) % GAMES_MOD;
                end else begin
                    mPerr = 1;
                end
            end else if ((w && !pW) && (l && !pL)) begin
                mPerr = 1;
            end else if (w && !pW) begin
                mWin    = (mWin + 1) % TALLY_MOD;
                r.kind  = 0;
                r.tally = mWin;
                doPush  = 1;
            end else if (l && !pL) begin
                mLose   = (mLose + 1) % TALLY_MOD;
                r.kind  = 1;
                r.tally = mLose;
                doPush  = 1;
            end
            if (popNow) begin
                void'(mQ.pop_front());
            end
            if (doPush) begin
                if (preSize == DEPTH && !popNow) begin
                    mOvf = 1;
                end else begin
                    mQ.push_back(r);
                end
            end
            pW = w; pL = l; pG = g;
            mTime = (mTime + 1) % 65536;
        end
    endtask

    // Drive one cycle's inputs, advance the model, and step past the edge
    // so outputs can be sampled 1 time unit after it.
    task automatic applyStimulus(input bit rst, input logic [3:0] cnt, input bit w,
                                 input bit l, input bit g, input logic [1:0] wh,
                                 input bit rdy);
        reset     = rst;
        counter   = cnt;
        winner    = w;
        loser     = l;
        gameover  = g;
        who       = wh;
        evt_ready = rdy;
        modelStep(rst, cnt, w, l, g, wh, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".valid"}, 32'(evt_valid), 32'(mQ.size() > 0));
        if (mQ.size() > 0) begin
            checkValue({tag, ".kind"}, 32'(evt_kind), mQ[0].kind);
            checkValue({tag, ".tally"}, 32'(evt_tally), mQ[0].tally);
            checkValue({tag, ".counter"}, 32'(evt_counter), mQ[0].cnt);
`ifdef OBS_TIMESTAMP_EN
            checkValue({tag, ".time"}, 32'(evt_time), mQ[0].stamp);
`endif
        end
        checkValue({tag, ".win"}, 32'(win_tally), mWin);
        checkValue({tag, ".lose"}, 32'(lose_tally), mLose);
        checkValue({tag, ".games"}, 32'(games_played), mGames);
        checkValue({tag, ".overflow"}, 32'(overflow), 32'(mOvf));
        checkValue({tag, ".proto_err"}, 32'(proto_err), 32'(mPerr));
    endtask

    initial begin
        reset = 1'b1; counter = 4'h0; winner = 1'b0; loser = 1'b0;
        gameover = 1'b0; who = 2'b00; evt_ready = 1'b0;

        // rst cnt w l g who rdy | valid kind tally cnt win lose games ovf perr
        vecs.push_back('{1, 4'h0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 4'hF, 1, 0, 0, 2'b00, 1, 1, 0, 1, 15, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 4'hF, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 4'hF, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 4'hF, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 4'hF, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 4'hF, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        vecs.push_back('{0, 4'h3, 1, 0, 0, 2'b00, 1, 1, 0, 2, 3, 2, 0, 0, 0, 0});
        vecs.push_back('{0, 4'h3, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0});
        vecs.push_back('{0, 4'h7, 0, 0, 1, 2'b10, 1, 1, 2, 2, 7, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 4'h7, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 4'h7, 0, 0, 1, 2'b11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1});
        vecs.push_back('{1, 4'h0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 4'h5, 1, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{0, 4'h5, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{1, 4'h0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back('{0, 4'h9, 0, 1, 0, 2'b00, 0, 1, 1, 1, 9, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 4'h9, 0, 0, 1, 2'b01, 0, 1, 1, 1, 9, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 4'h9, 0, 0, 0, 2'b00, 1, 1, 3, 0, 9, 0, 0, 1, 0, 0});
        vecs.push_back('{0, 4'h9, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0});

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i].rst, vecs[i].cnt, vecs[i].w, vecs[i].l,
                          vecs[i].g, vecs[i].wh, vecs[i].rdy);
            checkValue({tag, ".valid"}, 32'(evt_valid), 32'(vecs[i].eValid));
            if (vecs[i].eValid || vecs[i].rst) begin
                checkValue({tag, ".kind"}, 32'(evt_kind), vecs[i].eKind);
                checkValue({tag, ".tally"}, 32'(evt_tally), vecs[i].eTally);
                checkValue({tag, ".counter"}, 32'(evt_counter), vecs[i].eCnt);
            end
            checkValue({tag, ".win"}, 32'(win_tally), vecs[i].eWin);
            checkValue({tag, ".lose"}, 32'(lose_tally), vecs[i].eLose);
            checkValue({tag, ".games"}, 32'(games_played), vecs[i].eGames);
            checkValue({tag, ".overflow"}, 32'(overflow), 32'(vecs[i].eOvf));
            checkValue({tag, ".proto_err"}, 32'(proto_err), 32'(vecs[i].ePerr));
        end

        // Three win pulses then a won game: the game record holds 3.
        applyStimulus(1, 4'h0, 0, 0, 0, 2'b00, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 4'h2, 1, 0, 0, 2'b00, 1);
            applyStimulus(0, 4'h2, 0, 0, 0, 2'b00, 1);
        end
        checkValue("game3.win_before", 32'(win_tally), 3);
        applyStimulus(0, 4'hA, 0, 0, 1, 2'b10, 1);
        checkValue("game3.kind", 32'(evt_kind), 2);
        checkValue("game3.tally", 32'(evt_tally), 3);
        checkValue("game3.games", 32'(games_played), 1);
        checkValue("game3.win_after", 32'(win_tally), 0);
        checkOutput("game3");

        // Five lose pulses with the reader stalled: four queued, one dropped.
        applyStimulus(1, 4'h0, 0, 0, 0, 2'b00, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 4'h6, 0, 1, 0, 2'b00, 0);
            applyStimulus(0, 4'h6, 0, 0, 0, 2'b00, 0);
        end
        checkValue("ovf.flag", 32'(overflow), 1);
        checkValue("ovf.lose", 32'(lose_tally), 5);
        for (int k = 1; k <= 4; k++) begin
            checkValue($sformatf("ovf.drain%0d.valid", k), 32'(evt_valid), 1);
            checkValue($sformatf("ovf.drain%0d.kind", k), 32'(evt_kind), 1);
            checkValue($sformatf("ovf.drain%0d.tally", k), 32'(evt_tally), k);
            applyStimulus(0, 4'h6, 0, 0, 0, 2'b00, 1);
        end
        checkValue("ovf.empty", 32'(evt_valid), 0);

        // Full FIFO with push and pop together: both happen, no overflow.
        applyStimulus(1, 4'h0, 0, 0, 0, 2'b00, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 4'h1, 0, 1, 0, 2'b00, 0);
            applyStimulus(0, 4'h1, 0, 0, 0, 2'b00, 0);
        end
        applyStimulus(0, 4'hC, 0, 1, 0, 2'b00, 1);
        checkValue("fullpp.overflow", 32'(overflow), 0);
        checkValue("fullpp.head", 32'(evt_tally), 2);
        checkValue("fullpp.lose", 32'(lose_tally), 5);
        checkOutput("fullpp");

        // Events queued plus a sticky error, then a single reset cycle.
        applyStimulus(0, 4'h1, 1, 1, 0, 2'b00, 0);
        applyStimulus(0, 4'h1, 0, 0, 1, 2'b11, 0);
        checkValue("rstmid.perr_before", 32'(proto_err), 1);
        applyStimulus(1, 4'h0, 0, 0, 0, 2'b00, 0);
        checkValue("rstmid.valid", 32'(evt_valid), 0);
        checkValue("rstmid.win", 32'(win_tally), 0);
        checkValue("rstmid.lose", 32'(lose_tally), 0);
        checkValue("rstmid.games", 32'(games_played), 0);
        checkValue("rstmid.overflow", 32'(overflow), 0);
        checkValue("rstmid.perr", 32'(proto_err), 0);

`ifdef OBS_TIMESTAMP_EN
        // An edge seven cycles after reset carries timestamp 7.
        for (int k = 0; k < 7; k++) begin
            applyStimulus(0, 4'h0, 0, 0, 0, 2'b00, 0);
        end
        applyStimulus(0, 4'h4, 1, 0, 0, 2'b00, 0);
        checkValue("stamp.time", 32'(evt_time), 7);
`endif

        // Randomized run against the reference model.
        applyStimulus(1, 4'h0, 0, 0, 0, 2'b00, 0);
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          4'($urandom_range(0, 15)),
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 7) == 0,
                          2'($urandom_range(0, 3)),
                          $urandom_range(0, 2) != 0);
            checkOutput($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/counter_game_observer.md
Name: counter_game_observer

Overview:
- Passive observer on the output side of the up/down counter game. Samples counter, winner, loser, gameover and who.
- Edge-detects game events, keeps its own win/lose/game tallies and checks protocol consistency.
- Queues event records in a small FIFO, drained by a valid/ready reader (scoreboard, display or log unit).
- Only consumes the counter's outputs; never drives the counter.

Parameters:
- TALLY_W, 4: width of the win/lose tallies and of evt_tally.
- DEPTH, 4: event FIFO depth in entries; power of 2, at least 2.
- GAMES_W, 8: width of games_played.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- counter  in  4  game counter value.
- winner  in  1  win flag.
- loser  in  1  lose flag.
- gameover  in  1  game-over flag.
- who  in  2  game result: 2'b10 = win side, 2'b01 = lose side.
- evt_valid  out  1  FIFO head is valid.
- evt_ready  in  1  reader accepts the head.
- evt_kind  out  2  event kind: 00 WIN, 01 LOSE, 10 GAME_WIN, 11 GAME_LOSE.
- evt_tally  out  TALLY_W  tally value captured with the event.
- evt_counter  out  4  counter value sampled in the event cycle.
- win_tally  out  TALLY_W  running win count.
- lose_tally  out  TALLY_W  running lose count.
- games_played  out  GAMES_W  completed games.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- proto_err  out  1  sticky: protocol violation detected.

Behaviour:
- Reset: one clock with reset=1. All outputs go to 0, the FIFO empties, the edge-detect history registers clear and the sticky flags clear. A reset mid-operation discards queued events.
- Edge detection: rise_x = x & ~x_q, for x in {winner, loser, gameover}. x_q is the value of x registered on the previous clock.
  - After reset, x_q = 0, so an input already high in the first cycle counts as a rising edge.
- rise_winner alone: win_tally increments and wraps at 2^TALLY_W. Push WIN with evt_tally = the post-increment value.
- rise_loser alone: lose_tally increments and wraps. Push LOSE with evt_tally = the post-increment value.
- rise_winner and rise_loser in the same cycle: set proto_err. Neither tally changes and neither event is pushed.
- rise_gameover, who = 10: push GAME_WIN with evt_tally = win_tally before this cycle's update. games_played increments and wraps. win_tally and lose_tally clear to 0 at the end of the cycle.
- rise_gameover, who = 01: same as above, but push GAME_LOSE.
- rise_gameover, who = 00 or 11: set proto_err. Tallies are not cleared, games_played does not change, nothing is pushed.
- Push priority is one push per cycle. If gameover and winner/loser rise together, only the GAME event is pushed and the tally edge is ignored, because the tallies clear.
- evt_counter: the counter value sampled in the same cycle as the edge.
- FIFO:
  - First-word fall-through; evt_* reflect the head whenever evt_valid=1.
  - Pop happens on evt_valid & evt_ready.
  - Push when full without a pop: event dropped, overflow set; the tallies still update.
  - Push and pop in the same cycle when full: both succeed.
  - Push and pop in the same cycle when empty: the event appears on the next cycle, because the FIFO has no bypass.
  - evt_ready while empty has no effect.
  - Latency: edge at cycle N gives evt_valid=1 at cycle N+1.
- Sticky flags clear only on reset.

Optional Feature:
- Macro OBS_TIMESTAMP_EN.
- Defined: a 16-bit free-running cycle counter (reset to 0, wraps) is added. Each FIFO entry stores its value at the push cycle, and an extra output port evt_time [15:0] presents the head's timestamp.
- Undefined: no cycle counter, no timestamp storage, no evt_time port. All other behaviour is identical.

Decomposition:
- Package counter_game_pkg holds:
  - enum evt_kind_e: WIN, LOSE, GAME_WIN, GAME_LOSE.
  - who constants WHO_WIN = 2'b10 and WHO_LOSE = 2'b01.
  - packed struct evt_rec_t: kind, tally, counter, plus the optional time field.
- Sub-module obs_event_fifo: parameterised by DEPTH and the record type; push/pop/full/empty.
- Edge detect, tallies and checks stay in the top module.

Test Plan:
- Reset, then winner 0->1 with counter=4'hF and evt_ready=1 -> next cycle evt_valid=1, kind=WIN, evt_tally=1, evt_counter=F; win_tally=1.
- Winner held high for 5 cycles -> exactly one WIN event; win_tally=1.
- 3 winner pulses, then gameover rise with who=10 -> GAME_WIN event with evt_tally=3; games_played=1; win_tally=0 next cycle.
- evt_ready=0 and 5 loser pulses with DEPTH=4 -> 4 LOSE events queued with evt_tally 1..4; overflow=1; lose_tally=5.
- gameover rise with who=11 -> proto_err=1, no event pushed, games_played unchanged. Separately, winner and loser rising together -> proto_err=1, no event pushed.
- Events queued, then reset asserted for one cycle -> evt_valid=0, all tallies 0, overflow=0, proto_err=0. With OBS_TIMESTAMP_EN defined: an edge 7 cycles after reset -> evt_time=7.
